line_read_bridge: RTL and testbench
===================================

Name: line_read_bridge

Overview:
- AXI4 read-side responder that serves the Dcache read port of the prefetcher. It receives the prefetcher's forwarded request (rd_req/rd_type/rd_addr) and returns data as ret_valid/ret_data (256 bits).
- Converts each accepted request into one AXI AR transaction, either a single word or an 8-beat INCR burst. It collects the R beats and returns them as one 256-bit response.
- Sits between the prefetcher and the AXI crossbar. Only one request is outstanding at a time.

Parameters:
- AXI_ID, 4'd3, constant arid driven on every AR; R beats with other rid are ignored.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- rd_req  in  1  read request from prefetcher
- rd_type  in  1  0 = single word, 1 = 256-bit line (8 words)
- rd_addr  in  32  request byte address
- rd_rdy  out  1  request accepted this cycle when rd_req && rd_rdy
- ret_valid  out  1  one-cycle pulse, ret_data valid
- ret_data  out  256  returned data, word i at [32*i+31:32*i]
- arid  out  4  = AXI_ID
- araddr  out  32  read address
- arlen  out  8  0 (word) or 7 (line)
- arsize  out  3  3'd2
- arburst  out  2  2'b01 INCR
- arlock/arcache/arprot  out  2/4/3  constant 0
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  R id
- rdata  in  32  R data
- rresp  in  2  R response (ignored)
- rlast  in  1  last beat
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- FSM states: IDLE, AR, R, RET.
  - IDLE→AR on accept.
  - AR→R on arvalid && arready.
  - R→RET on the accepted beat with rlast=1.
  - RET→IDLE unconditionally.
- rd_rdy = (state==IDLE); combinational from state only, no dependence on rd_req.
- On accept, latch the request:
  - type;
  - address: araddr_q = rd_type ? {rd_addr[31:4],4'b0} : {rd_addr[31:2],2'b0};
  - beat counter cleared to 0;
  - ret_data cleared to 0.
- AR state:
  - arvalid=1; araddr/arlen stable until the handshake.
  - arlen = type ? 8'd7 : 8'd0.
  - Outputs held while arready=0, for any wait length.
- R state:
  - rready=1. A beat is accepted on rvalid && rready && rid==AXI_ID.
  - Each accepted beat writes rdata to ret_data word[cnt]; cnt increments as a 3-bit count.
  - rid mismatch: beat not consumed into data, and rready stays 1.
- Early rlast (fewer beats than arlen+1): go to RET; unwritten words remain 0.
- Extra beats after cnt=7 without rlast: cnt saturates at 7 and further data overwrites nothing. Only rlast ends R.
- Word request: ret_data[31:0]=rdata, bits [255:32]=0.
- RET: ret_valid=1 for exactly one cycle.
  - ret_data stays held until the next accept, so the prefetcher can latch [255:128] in the same cycle.
- Latency (zero-wait slave, arready=1 and rvalid in the cycle after AR):
  - accept at cycle 0, AR handshake at cycle 1;
  - beats at cycles 2..9 (line) or cycle 2 (word);
  - ret_valid at cycle 10 (line) or cycle 3 (word).
- rvalid in the same cycle as the AR handshake is not accepted; rready is 0 in the AR state.
- Reset values: state=IDLE, rd_rdy=1 (after reset), ret_valid=0, ret_data=0, arvalid=0, rready=0, araddr=0, arlen=0.
- Reset mid-transaction aborts to IDLE immediately. Draining outstanding beats is a system-reset concern; the bridge does not track them.

Test Plan:
- Line read, zero-wait slave: rd_type=1, rd_addr=0x1FC0_0014 → araddr=0x1FC0_0010, arlen=7. Beats 0x0..0x7 give ret_data word i = i. ret_valid pulses once, at accept+10.
- Word read: rd_type=0, rd_addr=0x8000_0006 → araddr=0x8000_0004, arlen=0. rdata=0xDEADBEEF gives ret_data=0x...0000_DEADBEEF with upper 224 bits zero, at accept+3.
- Backpressure: arready low 5 cycles, rvalid gaps of 2 cycles between beats → AR fields stable throughout, data correct. rd_rdy stays 0 until the cycle after ret_valid.
- Request while busy: rd_req held high during a burst → no second AR until IDLE. The second request is accepted the cycle after ret_valid, with the fresh araddr.
- Abnormal R: rid≠AXI_ID beat interleaved, then early rlast on beat 4 → the foreign beat is ignored, words 5..7 are 0, and ret_valid fires.
- Reset mid-burst after 3 beats → next cycle: arvalid=0, rready=0, ret_valid=0, rd_rdy=1. A new line read then completes correctly.

Source files
------------

// File: rtl/line_read_bridge.sv
// line_read_bridge: turns one prefetcher read request into a single AXI4 AR
// transaction (one word or an 8-beat INCR line). It gathers the R beats into
// a 256-bit line and returns it with a one-cycle ret_valid pulse.
//
// Handshakes: every channel is valid/ready. A transfer happens on a rising
// clk edge where both are high. Only the AR/R sides obey AXI hold rules.
// On the request side, rd_req && rd_rdy accepts the request in that cycle.
// ret_valid is a bare one-cycle pulse with no back-pressure.
module line_read_bridge #(
  parameter logic [3:0] AXI_ID = 4'd3
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic         rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic [255:0] ret_data,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic [1:0]   arlock,
  output logic [3:0]   arcache,
  output logic [2:0]   arprot,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;
  localparam logic [1:0] S_RET  = 2'd3;

  logic [1:0]   state;
  logic [31:0]  araddr_q;
  logic [7:0]   arlen_q;
  logic [2:0]   cnt;
  logic         full;
  logic [255:0] data_q;
  logic         beat_ok;

  // The response status is not reported upstream. The low address bits are
  // always realigned away.
  logic unused_bits;
  assign unused_bits = ^{rresp, rd_addr[1:0]};

  // A beat counts only in the R state and only when it carries our id.
  // Beats with a foreign id are dropped, rlast included.
  assign beat_ok = (state == S_R) && rvalid && (rid == AXI_ID);

  // Request/AR/R/RET sequencing plus the line assembly register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      araddr_q <= '0;
      arlen_q  <= '0;
      cnt      <= '0;
      full     <= 1'b0;
      data_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rd_req) begin
            state    <= S_AR;
            araddr_q <= rd_type ? {rd_addr[31:4], 4'b0} : {rd_addr[31:2], 2'b0};
            arlen_q  <= rd_type ? 8'd7 : 8'd0;
            cnt      <= '0;
            full     <= 1'b0;
            data_q   <= '0;
          end
        end
        S_AR: begin
          if (arready) state <= S_R;
        end
        S_R: begin
          if (beat_ok) begin
            // After word 7 has been written, surplus beats are consumed
            // without touching the line.
            if (!full) begin
              data_q[{cnt, 5'b0} +: 32] <= rdata;
              if (cnt == 3'd7) full <= 1'b1;
              else             cnt  <= cnt + 3'd1;
            end
            if (rlast) state <= S_RET;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rd_rdy    = (state == S_IDLE);
  assign arvalid   = (state == S_AR);
  assign rready    = (state == S_R);
  assign ret_valid = (state == S_RET);
  assign ret_data  = data_q;

  assign arid    = AXI_ID;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = 3'd2;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

endmodule

// File: tb/tb_line_read_bridge.sv
// Directed bench for line_read_bridge. A table of read scenarios is applied
// through one driver task that plays the AXI slave. Hand-written sequences
// cover request-while-busy and reset mid-burst.
module tb_line_read_bridge;

  logic         clk = 1'b0;
  logic         resetn;
  logic         rd_req, rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy, ret_valid;
  logic [255:0] ret_data;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst, arlock;
  logic [3:0]   arcache;
  logic [2:0]   arprot;
  logic         arvalid, arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  line_read_bridge dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_data(ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          rtype;
    logic [31:0] addr;
    logic [31:0] exp_araddr;
    logic [7:0]  exp_arlen;
    int          nb;       // beats sent with our id
    int          arw;      // cycles arready is held low
    int          gap;      // idle cycles before each beat
    int          foreign;  // beat index preceded by a foreign-id beat, -1 none
    logic [31:0] base;     // beat i carries base + i
    int          lat;      // expected cycles from accept to ret_valid
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver: issue one request and act as the AXI slave until the response.
  task automatic do_read(input vec_t v, input bit keep_req);
    int c0;
    logic [255:0] exp_data;
    exp_data = '0;
    for (int i = 0; i < v.nb && i < 8; i++) exp_data[i*32 +: 32] = v.base + i;

    rd_req = 1'b1; rd_type = v.rtype; rd_addr = v.addr;
    chk({v.name, "_rd_rdy_idle"}, rd_rdy, 1);
    c0 = cyc;
    step();
    if (keep_req) rd_addr = 32'h0BAD_0000;
    else          rd_req = 1'b0;

    chk({v.name, "_arvalid"}, arvalid, 1);
    chk({v.name, "_rd_rdy_busy"}, rd_rdy, 0);
    chk({v.name, "_rready_ar"}, rready, 0);
    chk({v.name, "_data_cleared"}, ret_data, 0);
    chk({v.name, "_araddr"}, araddr, v.exp_araddr);
    chk({v.name, "_arlen"}, arlen, v.exp_arlen);
    chk({v.name, "_arid"}, arid, 4'd3);
    chk({v.name, "_arsize"}, arsize, 3'd2);
    chk({v.name, "_arburst"}, arburst, 2'b01);
    chk({v.name, "_ar_consts"}, {arlock, arcache, arprot}, 0);

    for (int w = 0; w < v.arw; w++) begin
      arready = 1'b0;
      step();
      chk({v.name, "_arvalid_hold"}, arvalid, 1);
      chk({v.name, "_araddr_hold"}, araddr, v.exp_araddr);
      chk({v.name, "_arlen_hold"}, arlen, v.exp_arlen);
    end
    // Handshake cycle; an early R beat here must not be taken.
    arready = 1'b1;
    rvalid = 1'b1; rid = 4'd3; rdata = 32'hBADB_AD00; rlast = 1'b1;
    step();
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;

    for (int i = 0; i < v.nb; i++) begin
      for (int g = 0; g < v.gap; g++) step();
      if (i == v.foreign) begin
        chk({v.name, "_rready_foreign"}, rready, 1);
        rvalid = 1'b1; rid = 4'd5; rdata = 32'hF0F0_F0F0; rlast = 1'b1;
        step();
        rvalid = 1'b0; rlast = 1'b0;
      end
      chk({v.name, "_rready"}, rready, 1);
      chk({v.name, "_no_2nd_ar"}, arvalid, 0);
      chk({v.name, "_ret_early"}, ret_valid, 0);
      rvalid = 1'b1; rid = 4'd3; rdata = v.base + i; rlast = (i == v.nb - 1);
      step();
      rvalid = 1'b0; rlast = 1'b0;
    end

    chk({v.name, "_ret_valid"}, ret_valid, 1);
    chk({v.name, "_ret_data"}, ret_data, exp_data);
    chk({v.name, "_latency"}, cyc - c0, v.lat);
    chk({v.name, "_rd_rdy_ret"}, rd_rdy, 0);
    step();
    chk({v.name, "_ret_pulse"}, ret_valid, 0);
    chk({v.name, "_rd_rdy_after"}, rd_rdy, 1);
    chk({v.name, "_data_held"}, ret_data, exp_data);
  endtask

  initial begin
    vecs[0] = '{"line",     1'b1, 32'h1FC0_0014, 32'h1FC0_0010, 8'd7, 8,  0, 0, -1, 32'h0000_0000, 10};
    vecs[1] = '{"word",     1'b0, 32'h8000_0006, 32'h8000_0004, 8'd0, 1,  0, 0, -1, 32'hDEAD_BEEF, 3};
    vecs[2] = '{"bp_line",  1'b1, 32'h0000_1238, 32'h0000_1230, 8'd7, 8,  5, 2, -1, 32'hA000_0000, 31};
    vecs[3] = '{"bp_word",  1'b0, 32'h1234_5673, 32'h1234_5670, 8'd0, 1,  2, 1, -1, 32'h5555_AAAA, 6};
    vecs[4] = '{"abnormal", 1'b1, 32'h2000_00FF, 32'h2000_00F0, 8'd7, 5,  0, 0, 2,  32'h1111_0000, 8};
    vecs[5] = '{"extra",    1'b1, 32'h0000_0040, 32'h0000_0040, 8'd7, 10, 0, 0, -1, 32'h7700_0000, 12};

    resetn = 1'b0; rd_req = 1'b0; rd_type = 1'b0; rd_addr = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    repeat (3) step();
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_ret_data", ret_data, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    resetn = 1'b1;
    step();
    chk("rst_rd_rdy", rd_rdy, 1);

    for (int k = 0; k < 6; k++) do_read(vecs[k], 1'b0);

    // Request held high while busy: the second one is taken right after RET.
    do_read(vecs[0], 1'b1);
    do_read(vecs[1], 1'b0);

    // Reset after three beats of a line read.
    rd_req = 1'b1; rd_type = 1'b1; rd_addr = 32'h3000_0020;
    step();
    rd_req = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rvalid = 1'b1; rid = 4'd3; rdata = 32'hC000_0000 + i; rlast = 1'b0;
      step();
    end
    rvalid = 1'b0;
    resetn = 1'b0;
    step();
    chk("midrst_arvalid", arvalid, 0);
    chk("midrst_rready", rready, 0);
    chk("midrst_ret_valid", ret_valid, 0);
    chk("midrst_rd_rdy", rd_rdy, 1);
    chk("midrst_ret_data", ret_data, 0);
    resetn = 1'b1;
    step();
    do_read(vecs[0], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
